// File: rtl/dcache_flush_unit_if.sv
// Handshake bundle between the dcache flush sequencer
// and the flush controller / tag array / writeback unit.
interface dcache_flush_unit_if #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8
) ();
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                flush_i;
  logic                flush_ack_o;
  logic                busy_o;
  logic                tag_req_o;
  logic                tag_gnt_i;
  logic [SET_W-1:0]    tag_set_o;
  logic [NUM_WAYS-1:0] tag_valid_i;
  logic [NUM_WAYS-1:0] tag_dirty_i;
  logic                wb_req_o;
  logic [WAY_W-1:0]    wb_way_o;
  logic                wb_gnt_i;
  logic                inv_req_o;
  logic                inv_gnt_i;

  modport master (
    input  flush_i, tag_gnt_i, tag_valid_i,
    input  tag_dirty_i, wb_gnt_i, inv_gnt_i,
    output flush_ack_o, busy_o, tag_req_o,
    output tag_set_o, wb_req_o, wb_way_o,
    output inv_req_o
  );

  modport slave (
    output flush_i, tag_gnt_i, tag_valid_i,
    output tag_dirty_i, wb_gnt_i, inv_gnt_i,
    input  flush_ack_o, busy_o, tag_req_o,
    input  tag_set_o, wb_req_o, wb_way_o,
    input  inv_req_o
  );
endinterface

// File: rtl/dcache_flush_unit.sv
// Write-back dcache flush sequencer: walks every set,
// writes back valid+dirty ways, invalidates, then acks.
module dcache_flush_unit #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8
) (
  input logic clk_i,
  input logic rst_ni,
  dcache_flush_unit_if.master bus
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WB,
    S_INV,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [SET_W-1:0]    cnt_q;
  logic [NUM_WAYS-1:0] pend_q;
  logic [NUM_WAYS-1:0] pend_d;
  logic [NUM_WAYS-1:0] rem_d;
  logic [WAY_W-1:0]    way_q;
  logic                armed_q;
  logic                tag_req_q;
  logic                wb_req_q;
  logic                inv_req_q;
  logic                ack_q;
  logic                busy_q;

  function automatic logic [WAY_W-1:0] lowest(
    input logic [NUM_WAYS-1:0] v
  );
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

  assign pend_d = bus.tag_valid_i & bus.tag_dirty_i;
  assign rem_d  = pend_q & ~(NUM_WAYS'(1) << way_q);

  // Walk FSM; every output is a register set on state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      way_q     <= '0;
      armed_q   <= 1'b1;
      tag_req_q <= 1'b0;
      wb_req_q  <= 1'b0;
      inv_req_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.flush_i && armed_q) begin
            cnt_q     <= '0;
            tag_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_READ;
          end else if (!bus.flush_i) begin
            armed_q <= 1'b1;
          end
        end
        S_READ: begin
          if (bus.tag_gnt_i) begin
            tag_req_q <= 1'b0;
            state_q   <= S_CAPT;
          end
        end
        S_CAPT: begin
          pend_q <= pend_d;
          if (pend_d != '0) begin
            way_q    <= lowest(pend_d);
            wb_req_q <= 1'b1;
            state_q  <= S_WB;
          end else begin
            inv_req_q <= 1'b1;
            state_q   <= S_INV;
          end
        end
        S_WB: begin
          if (bus.wb_gnt_i) begin
            pend_q <= rem_d;
            if (rem_d != '0) begin
              way_q <= lowest(rem_d);
            end else begin
              wb_req_q  <= 1'b0;
              inv_req_q <= 1'b1;
              state_q   <= S_INV;
            end
          end
        end
        S_INV: begin
          if (bus.inv_gnt_i) begin
            inv_req_q <= 1'b0;
            if (cnt_q == LAST_SET) begin
              ack_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q     <= cnt_q + SET_W'(1);
              tag_req_q <= 1'b1;
              state_q   <= S_READ;
            end
          end
        end
        S_DONE: begin
          ack_q   <= 1'b0;
          armed_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          tag_req_q <= 1'b0;
          wb_req_q  <= 1'b0;
          inv_req_q <= 1'b0;
          ack_q     <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.flush_ack_o = ack_q;
  assign bus.busy_o      = busy_q;
  assign bus.tag_req_o   = tag_req_q;
  assign bus.tag_set_o   = cnt_q;
  assign bus.wb_req_o    = wb_req_q;
  assign bus.wb_way_o    = way_q;
  assign bus.inv_req_o   = inv_req_q;
endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit: directed walks,
// stalls, armed-flag behaviour, mid-walk reset, random grants.
module tb_dcache_flush_unit;
  localparam int NS = 4;
  localparam int NW = 8;

  localparam int EV_TAG = 0;
  localparam int EV_WB  = 1;
  localparam int EV_INV = 2;
  localparam int EV_ACK = 3;

  typedef struct {
    int kind;
    int set;
    int way;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_flush_unit_if #(.NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

  dcache_flush_unit #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  ev_t exp_q[$];
  logic [NW-1:0] vmem [NS];
  logic [NW-1:0] dmem [NS];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int wb_cnt = 0;
  int wb_stall = 0;
  bit gmode = 1'b0;
  bit sb_en = 1'b1;
  bit tag_hs = 1'b0;
  int tag_hs_set = 0;
  int lat;
  int a0;
  int w0;
  bit found;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_check(input int k, input int s, input int w);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb: unexpected kind=%0d set=%0d way=%0d", k, s, w);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.set != s || e.way != w) begin
        errors++;
        $display("FAIL sb: got kind=%0d set=%0d way=%0d expected kind=%0d set=%0d way=%0d",
                 k, s, w, e.kind, e.set, e.way);
      end
    end
  endtask

  task automatic push(input int k, input int s, input int w);
    ev_t e;
    e.kind = k;
    e.set  = s;
    e.way  = w;
    exp_q.push_back(e);
  endtask

  task automatic push_walk();
    logic [NW-1:0] p;
    for (int s = 0; s < NS; s++) begin
      push(EV_TAG, s, 0);
      p = vmem[s] & dmem[s];
      for (int w = 0; w < NW; w++) begin
        if (p[w]) push(EV_WB, s, w);
      end
      push(EV_INV, s, 0);
    end
    push(EV_ACK, 0, 0);
  endtask

  task automatic clear_mem();
    for (int s = 0; s < NS; s++) begin
      vmem[s] = '0;
      dmem[s] = '0;
    end
  endtask

  task automatic do_flush(input int hold_after, output int l);
    bit done;
    push_walk();
    @(negedge clk);
    bus.flush_i = 1'b1;
    l = 0;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      l++;
      if (bus.flush_ack_o) done = 1'b1;
    end
    chk("ack_timeout", int'(done), 1);
    for (int i = 0; i < hold_after; i++) begin
      @(negedge clk);
      chk("busy_after_ack", int'(bus.busy_o), 0);
    end
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // Monitor: handshakes seen mid-cycle feed the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      tag_hs = bus.tag_req_o && bus.tag_gnt_i;
      tag_hs_set = int'(bus.tag_set_o);
      if (bus.wb_req_o && bus.wb_gnt_i) wb_cnt++;
      if (bus.flush_ack_o) ack_cnt++;
      if (bus.tag_req_o || bus.wb_req_o || bus.inv_req_o)
        chk("req_exclusive", int'(bus.tag_req_o) + int'(bus.wb_req_o)
            + int'(bus.inv_req_o), 1);
      if (sb_en) begin
        if (tag_hs) sb_check(EV_TAG, tag_hs_set, 0);
        if (bus.wb_req_o && bus.wb_gnt_i)
          sb_check(EV_WB, int'(bus.tag_set_o), int'(bus.wb_way_o));
        if (bus.inv_req_o && bus.inv_gnt_i)
          sb_check(EV_INV, int'(bus.tag_set_o), 0);
        if (bus.flush_ack_o) sb_check(EV_ACK, 0, 0);
      end
    end
  end

  // Responder: tag data one cycle after grant, grants per mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tag_hs) begin
        bus.tag_valid_i = vmem[tag_hs_set];
        bus.tag_dirty_i = dmem[tag_hs_set];
      end else begin
        bus.tag_valid_i = NW'($urandom);
        bus.tag_dirty_i = NW'($urandom);
      end
      bus.tag_gnt_i = gmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wb_stall > 0 && bus.wb_req_o) begin
        bus.wb_gnt_i = 1'b0;
        wb_stall--;
      end else begin
        bus.wb_gnt_i = gmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      bus.inv_gnt_i = gmode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_ack"}, int'(bus.flush_ack_o), 0);
    chk({nm, "_busy"}, int'(bus.busy_o), 0);
    chk({nm, "_tag_req"}, int'(bus.tag_req_o), 0);
    chk({nm, "_wb_req"}, int'(bus.wb_req_o), 0);
    chk({nm, "_inv_req"}, int'(bus.inv_req_o), 0);
    chk({nm, "_set"}, int'(bus.tag_set_o), 0);
    chk({nm, "_way"}, int'(bus.wb_way_o), 0);
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.tag_gnt_i = 1'b0;
    bus.wb_gnt_i = 1'b0;
    bus.inv_gnt_i = 1'b0;
    bus.tag_valid_i = '0;
    bus.tag_dirty_i = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean cache, grants tied high: minimum latency.
    w0 = wb_cnt;
    a0 = ack_cnt;
    do_flush(1, lat);
    chk("t1_latency", lat, 3 * NS + 1);
    chk("t1_no_wb", wb_cnt - w0, 0);
    chk("t1_one_ack", ack_cnt - a0, 1);
    chk("t1_busy_low", int'(bus.busy_o), 0);

    // Set 2 pending = 8'b1000_0100: ways 2 then 7.
    vmem[2] = 8'b1010_0110;
    dmem[2] = 8'b1100_0101;
    w0 = wb_cnt;
    do_flush(1, lat);
    chk("t2_wb_count", wb_cnt - w0, 2);

    // Writeback grant stalled 5 cycles on way 2 of set 0.
    clear_mem();
    vmem[0] = 8'b0001_0100;
    dmem[0] = 8'b0001_0100;
    wb_stall = 5;
    found = 1'b0;
    fork
      do_flush(1, lat);
      begin
        for (int i = 0; i < 500 && !found; i++) begin
          @(negedge clk);
          if (bus.wb_req_o) found = 1'b1;
        end
        chk("t3_wb_seen", int'(found), 1);
        for (int k = 0; k < 6; k++) begin
          if (k > 0) @(negedge clk);
          chk("t3_hold_req", int'(bus.wb_req_o), 1);
          chk("t3_hold_way", int'(bus.wb_way_o), 2);
          chk("t3_hold_set", int'(bus.tag_set_o), 0);
        end
      end
    join

    // flush held past the ack: no restart, then a second walk.
    clear_mem();
    a0 = ack_cnt;
    do_flush(2, lat);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_restart", int'(bus.busy_o), 0);
    end
    do_flush(1, lat);
    chk("t4_two_acks", ack_cnt - a0, 2);

    // Reset while writing back set 1.
    vmem[1] = 8'b0000_0001;
    dmem[1] = 8'b0000_0001;
    sb_en = 1'b0;
    exp_q.delete();
    wb_stall = 1000;
    a0 = ack_cnt;
    @(negedge clk);
    bus.flush_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (bus.wb_req_o && bus.tag_set_o == 2'd1) found = 1'b1;
    end
    chk("t5_wb_set1", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_outs_zero("t5_rst");
    @(negedge clk);
    bus.flush_i = 1'b0;
    wb_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_ack", ack_cnt - a0, 0);
    chk("t5_idle", int'(bus.busy_o), 0);
    sb_en = 1'b1;
    do_flush(1, lat);
    chk("t5_restart_ack", ack_cnt - a0, 1);

    // Random dirty patterns with random grant stalls.
    gmode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        vmem[s] = NW'($urandom);
        dmem[s] = NW'($urandom);
      end
      a0 = ack_cnt;
      do_flush(1, lat);
      chk("t6_one_ack", ack_cnt - a0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_flush_unit.md
Name: dcache_flush_unit

Overview:
- Write-back data-cache flush sequencer. It sits directly downstream of the flush controller and consumes its registered flush_dcache request.
- Walks every set of the WB dcache. Issues a writeback for each valid+dirty way, then invalidates the whole set.
- Returns a single-cycle acknowledge when done; the controller uses it to clear its fence-active state.
- Asserts busy while walking so the cache miss/refill path is held off.

Parameters:
- NUM_SETS, 256, number of cache sets; power of two, >=2
- NUM_WAYS, 8, associativity; >=1
- SET_W, $clog2(NUM_SETS), set index width (derived)
- WAY_W, $clog2(NUM_WAYS) (min 1), way index width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  flush request level from the flush controller; held high until ack
- flush_ack_o  out  1  one-cycle pulse: all sets cleaned and invalidated
- busy_o  out  1  high in any state other than IDLE
- tag_req_o  out  1  tag/status array read request
- tag_gnt_i  in  1  tag array grant
- tag_set_o  out  SET_W  set index for the read/invalidate
- tag_valid_i  in  NUM_WAYS  per-way valid bits; valid exactly 1 cycle after the grant cycle
- tag_dirty_i  in  NUM_WAYS  per-way dirty bits; same timing as tag_valid_i
- wb_req_o  out  1  writeback request for (tag_set_o, wb_way_o)
- wb_way_o  out  WAY_W  way to write back
- wb_gnt_i  in  1  writeback accepted by the miss/writeback unit
- inv_req_o  out  1  write all-invalid, all-clean status for set tag_set_o
- inv_gnt_i  in  1  invalidate write accepted

Behaviour:
- Reset: every output 0; FSM=IDLE; set counter 0; armed=1.
- IDLE:
  - If flush_i && armed: set counter=0, go to READ.
  - If flush_i is low: armed=1.
- READ: tag_req_o=1, tag_set_o=counter. On tag_gnt_i go to CAPTURE. Request and set stay stable until granted.
- CAPTURE (1 cycle): pending = tag_valid_i & tag_dirty_i.
  - pending!=0: go to WB.
  - pending==0: go to INV.
- WB:
  - wb_req_o=1, wb_way_o=index of the lowest set bit of pending; set and way stable until wb_gnt_i.
  - On grant, clear that bit. If the remaining pending!=0, stay in WB with the next lowest way on the following cycle. Otherwise go to INV.
  - At most one writeback is issued per cycle. Writebacks are strictly in ascending way order.
- INV: inv_req_o=1, tag_set_o=counter; hold until inv_gnt_i.
  - On grant: if counter==NUM_SETS-1, go to DONE. Otherwise counter+=1 and go to READ.
- DONE (1 cycle): flush_ack_o=1, armed=0, go to IDLE.
  - The controller's flush level is registered, so flush_i may still be high for 1 cycle after the ack. The armed flag blocks a spurious restart.
  - A new flush starts only after flush_i has been seen low in IDLE.
- Counter arithmetic:
  - Unsigned, SET_W bits. Termination is by an explicit compare with NUM_SETS-1, never by counter wrap.
  - The counter is never observed at NUM_SETS.
- flush_i deasserting mid-walk is ignored; the walk always completes and acks. The controller contract forbids this, and the unit must not hang if it happens.
- Request signals never drop before their grant. tag_req_o, wb_req_o and inv_req_o are mutually exclusive in every cycle.
- Grants arriving while the matching request is low are ignored.
- busy_o = (state != IDLE); the DONE cycle counts as busy.
- Async reset mid-walk returns immediately to IDLE with armed=1; no ack is issued. Partially flushed sets are left as-is.
- Minimum latency, no dirty lines, all grants same-cycle: 3 cycles per set (READ, CAPTURE, INV) + 1 (DONE). The ack arrives 3*NUM_SETS+1 cycles after flush_i is sampled.

Test Plan:
- Clean cache, NUM_SETS=4, grants tied high: pulse flush_i -> tag_set_o sequences 0..3, no wb_req_o, 4 inv grants, flush_ack_o high at cycle 13, busy_o low after.
- Set 2 with valid=8'b1010_0110, dirty=8'b1100_0101 -> exactly 2 writebacks on set 2, way 2 then way 7; then inv of set 2.
- wb_gnt_i stalled 5 cycles on the first dirty way -> wb_req_o/wb_way_o/tag_set_o held constant for all 6 cycles, no skipped or duplicate way.
- flush_i held high 2 cycles past the ack -> no second walk. Drop flush_i for 1 cycle, raise it again -> a second full walk and a second ack.
- Reset asserted during WB of set 1 -> all outputs 0 immediately, FSM in IDLE. A fresh flush restarts from set 0 and acks normally.
- Randomized tag/wb/inv grant stalls with random dirty patterns (scoreboard): every valid+dirty way written back exactly once, every set invalidated exactly once, exactly one ack per accepted flush.
